// File: rtl/timer_alarm_sched_pkg.sv
// Shared definitions for the four-channel alarm scheduler: register offsets,
// channel count, channel state encoding and the IRQID "nothing pending" value.
package timer_alarm_sched_pkg;

   localparam int          NCH_DEFAULT = 4;
   localparam logic [31:0] IRQID_NONE  = 32'hFFFF_FFFF;

   localparam logic [31:0] OFF_CMP0  = 32'h00;
   localparam logic [31:0] OFF_CTRL  = 32'h10;
   localparam logic [31:0] OFF_PEND  = 32'h14;
   localparam logic [31:0] OFF_IRQID = 32'h18;
   localparam logic [31:0] OFF_PER0  = 32'h20;

   typedef enum logic [1:0] {
      CH_IDLE  = 2'd0,
      CH_ARMED = 2'd1,
      CH_FIRE  = 2'd2
   } ch_state_e;

endpackage

// File: rtl/timer_alarm_sched_if.sv
// Peripheral bus port of the alarm scheduler: write strobe, address, data and
// the registered read-data return.
interface timer_alarm_sched_if;
   logic        wen;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output wen, addr, wdata, input rdata);
   modport slave  (input wen, addr, wdata, output rdata);
endinterface

// File: rtl/timer_alarm_sched_alarm_channel.sv
// One alarm channel: IDLE/ARMED/FIRE sequencer, CMP/PER registers, wrap-safe
// due compare and the drift-free periodic reload.
module alarm_channel
   import timer_alarm_sched_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] tick_cnt,
   input  logic [31:0] wdata,
   input  logic        cmp_we,
   input  logic        per_we,
   input  logic        en_wr1,
   input  logic        en_wr0,
   input  logic        per_mode,
   output logic [31:0] cmp,
   output logic [31:0] per,
   output logic        fire,
   output logic        done
);

   ch_state_e   state, state_nxt;
   logic [31:0] diff;
   logic        due, reload;

   // Due once the counter is at or past the compare, within half the range.
   assign diff = tick_cnt - cmp;
   assign due  = ~diff[31];

   always_ff @(posedge clk) begin
      if (rst) state <= CH_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (en_wr0) begin
         state_nxt = CH_IDLE;
      end else begin
         case (state)
            CH_IDLE:  if (en_wr1) state_nxt = CH_ARMED;
            CH_ARMED: if (due)    state_nxt = CH_FIRE;
            CH_FIRE:  state_nxt = (reload || en_wr1) ? CH_ARMED : CH_IDLE;
            default:  state_nxt = CH_IDLE;
         endcase
      end
   end

   // fire marks the ARMED->FIRE edge so PEND lands together with FIRE.
   always_comb begin
      fire   = (state == CH_ARMED) && due && !en_wr0;
      reload = (state == CH_FIRE) && per_mode && (per != '0);
      done   = (state == CH_FIRE) && !reload;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cmp <= '0;
         per <= '0;
      end else begin
         if (cmp_we)      cmp <= wdata;
         else if (reload) cmp <= cmp + per;
         if (per_we)      per <= wdata;
      end
   end

endmodule

// File: rtl/timer_alarm_sched.sv
// Alarm scheduler top: bus decode, CTRL/PEND registers, lowest-index IRQID
// encoder, registered read mux and the level interrupt.
module timer_alarm_sched
   import timer_alarm_sched_pkg::*;
#(
   parameter logic [31:0] BASE = 32'hFFFF_F100,
   parameter int          NCH  = NCH_DEFAULT
) (
   input  logic                clk,
   input  logic                rst,
   timer_alarm_sched_if.slave  bus,
   input  logic [31:0]         tick_cnt,
   output logic                irq
);

   logic [31:0]           off, irqid, rd_nxt;
   logic                  ctrl_we, pend_we;
   logic [NCH-1:0]        en, per_mode, pend, fire, done, cmp_we, per_we;
   logic [NCH-1:0][31:0]  cmp, per;

   assign off     = bus.addr - BASE;
   assign ctrl_we = bus.wen && (off == OFF_CTRL);
   assign pend_we = bus.wen && (off == OFF_PEND);

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      assign cmp_we[i] = bus.wen && (off == OFF_CMP0 + 32'(4 * i));
      assign per_we[i] = bus.wen && (off == OFF_PER0 + 32'(4 * i));

      alarm_channel u_ch (
         .clk      (clk),
         .rst      (rst),
         .tick_cnt (tick_cnt),
         .wdata    (bus.wdata),
         .cmp_we   (cmp_we[i]),
         .per_we   (per_we[i]),
         .en_wr1   (ctrl_we && bus.wdata[i]),
         .en_wr0   (ctrl_we && !bus.wdata[i]),
         .per_mode (per_mode[i]),
         .cmp      (cmp[i]),
         .per      (per[i]),
         .fire     (fire[i]),
         .done     (done[i])
      );
   end

   // A software CTRL write overrides the hardware EN clear of a finishing alarm.
   always_ff @(posedge clk) begin
      if (rst) begin
         en       <= '0;
         per_mode <= '0;
      end else if (ctrl_we) begin
         en       <= bus.wdata[NCH-1:0];
         per_mode <= bus.wdata[4 +: NCH];
      end else begin
         en       <= en & ~done;
      end
   end

   // Set has priority over write-1-to-clear.
   always_ff @(posedge clk) begin
      if (rst) pend <= '0;
      else     pend <= (pend & ~(pend_we ? bus.wdata[NCH-1:0] : '0)) | fire;
   end

   assign irq = |pend;

   always_comb begin
      irqid = IRQID_NONE;
      for (int i = NCH - 1; i >= 0; i--)
         if (pend[i]) irqid = 32'(i);
   end

   always_comb begin
      rd_nxt = '0;
      for (int i = 0; i < NCH; i++) begin
         if (off == OFF_CMP0 + 32'(4 * i)) rd_nxt = cmp[i];
         if (off == OFF_PER0 + 32'(4 * i)) rd_nxt = per[i];
      end
      if (off == OFF_CTRL)  rd_nxt = 32'({per_mode, en});
      if (off == OFF_PEND)  rd_nxt = 32'(pend);
      if (off == OFF_IRQID) rd_nxt = irqid;
   end

   always_ff @(posedge clk) begin
      if (rst) bus.rdata <= '0;
      else     bus.rdata <= rd_nxt;
   end

endmodule

// File: tb/tb_timer_alarm_sched.sv
// Self-checking bench for timer_alarm_sched: register table, directed alarm
// sequences, and randomized ramps checked against predicted fire ticks.
module tb_timer_alarm_sched;
   import timer_alarm_sched_pkg::*;

   localparam logic [31:0] BASE = 32'hFFFF_F100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] tick_cnt = '0;
   logic        irq;

   timer_alarm_sched_if bus ();

   timer_alarm_sched #(.BASE(BASE), .NCH(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .tick_cnt (tick_cnt),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic        wen;
      logic [31:0] off;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[$];

   // Random-round programming, used by the fire-tick predictor
   logic [31:0] r_cmp [4];
   logic [31:0] r_per [4];
   logic        r_pm  [4];
   logic        r_en  [4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] off, input logic [31:0] data);
      bus.wen   = 1'b1;
      bus.addr  = BASE + off;
      bus.wdata = data;
      step();
      bus.wen   = 1'b0;
   endtask

   task automatic rd(input logic [31:0] off, output logic [31:0] data);
      bus.wen  = 1'b0;
      bus.addr = BASE + off;
      step();
      data = bus.rdata;
   endtask

   task automatic do_reset();
      bus.wen = 1'b0;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   // An alarm fires when the counter lands exactly on cmp + k*per (per >= 2
   // under a +1 ramp), or exactly on cmp for one-shot.
   function automatic logic [3:0] fire_vec(input logic [31:0] t);
      logic [3:0]  v;
      logic [31:0] d;
      v = '0;
      for (int c = 0; c < 4; c++) begin
         d = t - r_cmp[c];
         if (r_en[c] && d < 32'd1000) begin
            if (r_pm[c] && r_per[c] != 0) v[c] = (d % r_per[c]) == 0;
            else                          v[c] = (d == 0);
         end
      end
      return v;
   endfunction

   initial begin
      logic [31:0] rv, t, t0;
      logic [3:0]  prev, cur;
      logic [5:0]  pat;
      logic        pexp, w1c, fired;

      bus.wen = 1'b0; bus.addr = '0; bus.wdata = '0;

      // Reset held two cycles while writes are attempted
      bus.wen = 1'b1; bus.addr = BASE; bus.wdata = 32'h1234_5678;
      step();
      bus.addr = BASE + OFF_CTRL; bus.wdata = 32'hFF;
      step();
      bus.wen = 1'b0;
      chk("rst_irq", {31'd0, irq}, 32'd0);
      chk("rst_rdata", bus.rdata, 32'd0);
      rst = 1'b0;
      rd(OFF_CMP0, rv);  chk("rst_cmp0", rv, 32'd0);
      rd(OFF_CTRL, rv);  chk("rst_ctrl", rv, 32'd0);
      rd(OFF_PEND, rv);  chk("rst_pend", rv, 32'd0);
      rd(OFF_IRQID, rv); chk("rst_irqid", rv, 32'hFFFF_FFFF);

      // Register table: rdata after each edge is the pre-write value
      tbl.push_back('{1'b1, 32'h00, 32'h1111_1111, 32'h0});
      tbl.push_back('{1'b1, 32'h04, 32'h2222_2222, 32'h0});
      tbl.push_back('{1'b1, 32'h28, 32'h0000_0033, 32'h0});
      tbl.push_back('{1'b1, 32'h10, 32'h0000_00F0, 32'h0});
      tbl.push_back('{1'b0, 32'h00, 32'h0,         32'h1111_1111});
      tbl.push_back('{1'b0, 32'h04, 32'h0,         32'h2222_2222});
      tbl.push_back('{1'b0, 32'h28, 32'h0,         32'h0000_0033});
      tbl.push_back('{1'b0, 32'h10, 32'h0,         32'h0000_00F0});
      tbl.push_back('{1'b1, 32'h10, 32'hFFFF_FF50, 32'h0000_00F0});
      tbl.push_back('{1'b0, 32'h10, 32'h0,         32'h0000_0050});
      tbl.push_back('{1'b1, 32'h1C, 32'hDEAD_BEEF, 32'h0});
      tbl.push_back('{1'b0, 32'h1C, 32'h0,         32'h0});
      tbl.push_back('{1'b1, 32'h18, 32'h5,         32'hFFFF_FFFF});
      tbl.push_back('{1'b0, 32'h18, 32'h0,         32'hFFFF_FFFF});
      tbl.push_back('{1'b0, 32'h14, 32'h0,         32'h0});
      tbl.push_back('{1'b0, 32'h30, 32'h0,         32'h0});
      tbl.push_back('{1'b0, 32'hFFFF_FFFC, 32'h0,  32'h0});
      tbl.push_back('{1'b0, 32'h2C, 32'h0,         32'h0});
      foreach (tbl[i]) begin
         bus.wen   = tbl[i].wen;
         bus.addr  = BASE + tbl[i].off;
         bus.wdata = tbl[i].wdata;
         step();
         chk($sformatf("tbl%0d", i), bus.rdata, tbl[i].exp);
      end
      bus.wen = 1'b0;
      chk("tbl_irq", {31'd0, irq}, 32'd0);

      // One-shot on ch0 at 100
      do_reset();
      tick_cnt = 0;
      wr(OFF_CMP0, 32'd100);
      wr(OFF_CTRL, 32'h1);
      bus.addr = BASE + OFF_PEND;
      for (int k = 90; k <= 105; k++) begin
         tick_cnt = k;
         step();
         chk($sformatf("os_irq_t%0d", k), {31'd0, irq}, (k >= 100) ? 32'd1 : 32'd0);
      end
      rd(OFF_PEND, rv); chk("os_pend", rv, 32'h1);
      rd(OFF_CTRL, rv); chk("os_ctrl", rv, 32'h0);
      wr(OFF_PEND, 32'h1);
      chk("os_w1c_irq", {31'd0, irq}, 32'd0);

      // Periodic ch1 across the counter wrap
      do_reset();
      tick_cnt = 32'hFFFF_FFE0;
      wr(32'h04, 32'hFFFF_FFF0);
      wr(32'h24, 32'h20);
      wr(OFF_CTRL, 32'h22);
      pexp = 1'b0;
      for (int k = 0; k < 32'h58; k++) begin
         t = 32'hFFFF_FFE8 + 32'(k);
         tick_cnt = t;
         w1c = (t == 32'h0) || (t == 32'h20);
         bus.wen   = w1c;
         bus.addr  = BASE + (w1c ? OFF_PEND : 32'h04);
         bus.wdata = 32'h2;
         step();
         fired = (t == 32'hFFFF_FFF0) || (t == 32'h10) || (t == 32'h30);
         pexp  = fired || (pexp && !w1c);
         chk($sformatf("per_irq_t%h", t), {31'd0, irq}, {31'd0, pexp});
         if (t == 32'hFFFF_FFF8) chk("per_cmp1", bus.rdata, 32'h10);
      end
      bus.wen = 1'b0;

      // Compare already in the past, then exactly half a range ahead
      do_reset();
      tick_cnt = 32'd500;
      wr(32'h08, 32'd400);
      wr(OFF_CTRL, 32'h4);
      step();
      step();
      chk("past_irq", {31'd0, irq}, 32'd1);
      wr(OFF_CTRL, 32'h0);
      wr(OFF_PEND, 32'hF);
      wr(32'h08, 32'd500 + 32'h8000_0000);
      wr(OFF_CTRL, 32'h4);
      repeat (10) step();
      chk("far_irq", {31'd0, irq}, 32'd0);
      rd(OFF_CTRL, rv); chk("far_ctrl", rv, 32'h4);

      // PER=1 refire under continuous W1C: set must beat clear
      do_reset();
      tick_cnt = 32'd1000;
      wr(32'h0C, 32'd990);
      wr(32'h2C, 32'd1);
      wr(OFF_CTRL, 32'h88);
      bus.wen = 1'b1; bus.addr = BASE + OFF_PEND; bus.wdata = 32'h8;
      for (int k = 0; k < 6; k++) begin
         step();
         pat[k] = irq;
      end
      bus.wen = 1'b0;
      chk("p1_pattern", {26'd0, pat}, 32'h15);

      // EN write-0 in the due cycle suppresses the fire
      do_reset();
      tick_cnt = 32'd40;
      wr(OFF_CMP0, 32'd50);
      wr(OFF_CTRL, 32'h1);
      tick_cnt = 32'd49;
      step();
      tick_cnt = 32'd50;
      wr(OFF_CTRL, 32'h0);
      chk("kill_irq", {31'd0, irq}, 32'd0);
      tick_cnt = 32'd52;
      step();
      rd(OFF_PEND, rv); chk("kill_pend", rv, 32'h0);

      // ch1 and ch3 due together: lowest index first
      do_reset();
      tick_cnt = 32'd2000;
      wr(32'h04, 32'd2010);
      wr(32'h0C, 32'd2010);
      wr(OFF_CTRL, 32'h0A);
      for (int k = 2005; k <= 2012; k++) begin
         tick_cnt = k;
         step();
      end
      rd(OFF_PEND, rv);  chk("pri_pend", rv, 32'hA);
      rd(OFF_IRQID, rv); chk("pri_id1", rv, 32'd1);
      wr(OFF_PEND, 32'h2);
      rd(OFF_IRQID, rv); chk("pri_id3", rv, 32'd3);
      chk("pri_irq", {31'd0, irq}, 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_irq", {31'd0, irq}, 32'd0);

      // Randomized rounds: predicted fire ticks vs irq and PEND readback
      for (int r = 0; r < 6; r++) begin
         t0 = $urandom;
         tick_cnt = t0;
         do_reset();
         for (int c = 0; c < 4; c++) begin
            r_cmp[c] = t0 + $urandom_range(3, 60);
            r_pm[c]  = 1'($urandom_range(0, 1));
            r_per[c] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom_range(2, 40);
            r_en[c]  = 1'($urandom_range(0, 1));
            wr(32'(4 * c), r_cmp[c]);
            wr(OFF_PER0 + 32'(4 * c), r_per[c]);
         end
         wr(OFF_CTRL, {24'd0, r_pm[3], r_pm[2], r_pm[1], r_pm[0],
                       r_en[3], r_en[2], r_en[1], r_en[0]});
         bus.wen = 1'b1; bus.addr = BASE + OFF_PEND; bus.wdata = 32'hF;
         prev = '0;
         for (int k = 0; k < 120; k++) begin
            tick_cnt = t0 + 32'(k);
            step();
            cur = fire_vec(t0 + 32'(k));
            chk($sformatf("rnd%0d_irq_k%0d", r, k), {31'd0, irq}, {31'd0, |cur});
            chk($sformatf("rnd%0d_pend_k%0d", r, k), bus.rdata, {28'd0, prev});
            prev = cur;
         end
         bus.wen = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
